// File: rtl/fanctrl_pkg.sv
// ----------------------------------------------------------------------------
// fanctrl_pkg
// Shared definitions for the FanCTRL front end: the ADC sampler FSM state
// encoding, the default ADC result width, and a helper that gives the length
// of one conversion (csn low window + csn hold + one accumulate cycle) in
// clk_i cycles.
// ----------------------------------------------------------------------------
package fanctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        ACCUM
    } adc_state_e;

    localparam int ADC_BITWIDTH_DEFAULT = 8;

    // CS_SETUP (clk_div) + SHIFT (2*clk_div per bit) + CS_HOLD (clk_div) + ACCUM (1)
    function automatic int conv_cycles(input int clk_div, input int lead_bits, input int bitwidth);
        return clk_div * (2 * (lead_bits + bitwidth) + 2) + 1;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// ----------------------------------------------------------------------------
// adc_sclk_gen
// Generates N_PERIODS serial-clock periods after a start pulse. Each period is
// CLK_DIV clk_i cycles low followed by CLK_DIV cycles high; sclk rests low.
//
// Ports:
//   clk_i    in   system clock
//   rst_i    in   synchronous active-high reset
//   start_i  in   begin a burst of N_PERIODS periods (sclk low phase first)
//   sclk_o   out  registered serial clock
//   rise_o   out  high in the cycle whose closing edge drives sclk 0->1
//   done_o   out  high in the cycle whose closing edge ends the last high phase
// ----------------------------------------------------------------------------
module adc_sclk_gen #(
    parameter int CLK_DIV   = 4,
    parameter int N_PERIODS = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic sclk_o,
    output logic rise_o,
    output logic done_o
);

    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = (N_PERIODS > 1) ? $clog2(N_PERIODS) : 1;
    localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(N_PERIODS - 1);

    logic              active_q, active_d;
    logic              sclk_q, sclk_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              half_tc;

    assign half_tc = active_q && (half_q == '0);
    assign rise_o  = half_tc && !sclk_q;
    assign done_o  = half_tc && sclk_q && (bit_q == '0);
    assign sclk_o  = sclk_q;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        half_d   = half_q;
        bit_d    = bit_q;
        if (start_i) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            half_d   = HALF_LOAD;
            bit_d    = BIT_LOAD;
        end else if (active_q) begin
            if (half_q == '0) begin
                half_d = HALF_LOAD;
                sclk_d = !sclk_q;
                // A period is counted off at the end of its high phase.
                if (sclk_q) begin
                    if (bit_q == '0) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end else begin
                half_d = half_q - HALF_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            half_q   <= '0;
            bit_q    <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// ----------------------------------------------------------------------------
// adc_spi_sampler
// Reads an MCP3001-style ADC over CSn/SCLK/MISO once every SAMPLE_PERIOD
// cycles, averages 2^AVG_LOG2 conversions and presents the result with a
// one-cycle strobe for FanCTRL.
//
// Ports:
//   clk_i             in   system clock
//   rst_i             in   synchronous active-high reset
//   en_i              in   sampling enable
//   adc_miso_i        in   serial data from ADC, MSB first
//   adc_sclk_o        out  serial clock, idle low
//   adc_csn_o         out  chip select, active low
//   ADC_value_o       out  averaged sample, held between strobes
//   dataValid_STRB_o  out  one-cycle pulse when ADC_value_o updates
//   busy_o            out  conversion in flight (CS_SETUP through ACCUM)
//   sat_o             out  (ADC_SAT_FLAG_EN only) an all-ones raw sample was
//                          seen in the averaging window just reported
//
// Build option: define ADC_SAT_FLAG_EN to add the sat_o port and its logic.
//
// Legal configurations need SAMPLE_PERIOD > conv_cycles(...); a period
// terminal count that arrives while a conversion is in flight is dropped.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | csn high, waiting for period terminal count
// CS_SETUP | csn low, sclk low for CLK_DIV cycles
// SHIFT    | LEAD_BITS+ADC_BITWIDTH sclk periods, miso sampled on rise
// CS_HOLD  | csn high for CLK_DIV cycles
// ACCUM    | add raw sample to the window, strobe when the window is full
// ----------------------------------------------------------------------------
module adc_spi_sampler
    import fanctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH  = ADC_BITWIDTH_DEFAULT,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int AVG_LOG2      = 2,
    parameter int LEAD_BITS     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    adc_miso_i,
    output logic                    adc_sclk_o,
    output logic                    adc_csn_o,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataValid_STRB_o,
    output logic                    busy_o
`ifdef ADC_SAT_FLAG_EN
    ,
    output logic                    sat_o
`endif
);

    localparam int N_BITS = LEAD_BITS + ADC_BITWIDTH;
    localparam int ACC_W  = ADC_BITWIDTH + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMR_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CONV_CYCLES = conv_cycles(CLK_DIV, LEAD_BITS, ADC_BITWIDTH);

    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] AVG_COUNT = CNT_W'(1) << AVG_LOG2;

    if (SAMPLE_PERIOD <= CONV_CYCLES) begin : g_period_check
        $error("adc_spi_sampler: SAMPLE_PERIOD too short for one conversion");
    end

    adc_state_e              state_q, state_d;
    logic [PER_W-1:0]        per_q, per_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [ADC_BITWIDTH-1:0] shift_q, shift_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADC_BITWIDTH-1:0] value_q, value_d;
    logic                    strb_q, strb_d;
    logic                    csn_q, csn_d;
    logic                    busy_q, busy_d;
`ifdef ADC_SAT_FLAG_EN
    logic                    sat_acc_q, sat_acc_d;
    logic                    sat_q, sat_d;
`endif

    logic             per_tc;
    logic             sclk_start;
    logic             sclk_rise;
    logic             sclk_done;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;

    adc_sclk_gen #(
        .CLK_DIV   (CLK_DIV),
        .N_PERIODS (N_BITS)
    ) u_sclk_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (sclk_start),
        .sclk_o  (adc_sclk_o),
        .rise_o  (sclk_rise),
        .done_o  (sclk_done)
    );

    assign per_tc  = (per_q == PER_LAST);
    assign acc_sum = acc_q + ACC_W'(shift_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        strb_d     = 1'b0;
        sclk_start = 1'b0;
`ifdef ADC_SAT_FLAG_EN
        sat_acc_d  = sat_acc_q;
        sat_d      = sat_q;
`endif

        per_d = en_i ? (per_tc ? '0 : per_q + PER_W'(1)) : '0;

        // Shifting all N_BITS through an ADC_BITWIDTH register pushes the
        // lead bits out the top, leaving only the data bits.
        if (sclk_rise) begin
            shift_d = {shift_q[ADC_BITWIDTH-2:0], adc_miso_i};
        end

        case (state_q)
            IDLE: begin
                if (!en_i) begin
                    acc_d = '0;
                    cnt_d = '0;
`ifdef ADC_SAT_FLAG_EN
                    sat_acc_d = 1'b0;
`endif
                end else if (per_tc) begin
                    state_d = CS_SETUP;
                    tmr_d   = TMR_LOAD;
                end
            end
            CS_SETUP: begin
                if (tmr_q == '0) begin
                    state_d    = SHIFT;
                    sclk_start = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            SHIFT: begin
                if (sclk_done) begin
                    state_d = CS_HOLD;
                    tmr_d   = TMR_LOAD;
                end
            end
            CS_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = ACCUM;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ACCUM: begin
                state_d = IDLE;
                // A conversion finished after en_i dropped is not counted.
                if (en_i) begin
                    if (cnt_inc == AVG_COUNT) begin
                        value_d = ADC_BITWIDTH'(acc_sum >> AVG_LOG2);
                        strb_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
`ifdef ADC_SAT_FLAG_EN
                        sat_d     = sat_acc_q | (&shift_q);
                        sat_acc_d = 1'b0;
`endif
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
`ifdef ADC_SAT_FLAG_EN
                        sat_acc_d = sat_acc_q | (&shift_q);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        csn_d  = !((state_d == CS_SETUP) || (state_d == SHIFT));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            per_q     <= '0;
            tmr_q     <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            strb_q    <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef ADC_SAT_FLAG_EN
            sat_acc_q <= 1'b0;
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            tmr_q     <= tmr_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            strb_q    <= strb_d;
            csn_q     <= csn_d;
            busy_q    <= busy_d;
`ifdef ADC_SAT_FLAG_EN
            sat_acc_q <= sat_acc_d;
            sat_q     <= sat_d;
`endif
        end
    end

    assign adc_csn_o        = csn_q;
    assign ADC_value_o      = value_q;
    assign dataValid_STRB_o = strb_q;
    assign busy_o           = busy_q;
`ifdef ADC_SAT_FLAG_EN
    assign sat_o            = sat_q;
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// ----------------------------------------------------------------------------
// tb_adc_spi_sampler
// Bench for adc_spi_sampler with CLK_DIV=2, SAMPLE_PERIOD=64, AVG_LOG2=2,
// LEAD_BITS=2. A behavioural ADC serves raw samples from a queue; expected
// averages are queued up front and compared as strobes arrive. Bus timing,
// strobe width, output hold, reset and enable behaviour are also checked.
// Define ADC_SAT_FLAG_EN to also check sat_o.
// ----------------------------------------------------------------------------
module tb_adc_spi_sampler;

    localparam int W    = 8;
    localparam int CDIV = 2;
    localparam int SP   = 64;
    localparam int AVGL = 2;
    localparam int LEAD = 2;
    localparam int NB   = LEAD + W;                     // 10 sclk periods
    localparam int CSN_LOW = CDIV + 2 * CDIV * NB;      // 42
    localparam int CONV    = CSN_LOW + CDIV + 1;        // 45
    localparam int FIRST_STROBE = 3 * SP + CONV;        // 237

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         en_i  = 1'b0;
    logic         adc_miso_i = 1'b0;
    logic         adc_sclk_o;
    logic         adc_csn_o;
    logic [W-1:0] ADC_value_o;
    logic         dataValid_STRB_o;
    logic         busy_o;
`ifdef ADC_SAT_FLAG_EN
    logic         sat_o;
`endif

    adc_spi_sampler #(
        .ADC_BITWIDTH  (W),
        .CLK_DIV       (CDIV),
        .SAMPLE_PERIOD (SP),
        .AVG_LOG2      (AVGL),
        .LEAD_BITS     (LEAD)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .en_i             (en_i),
        .adc_miso_i       (adc_miso_i),
        .adc_sclk_o       (adc_sclk_o),
        .adc_csn_o        (adc_csn_o),
        .ADC_value_o      (ADC_value_o),
        .dataValid_STRB_o (dataValid_STRB_o),
        .busy_o           (busy_o)
`ifdef ADC_SAT_FLAG_EN
        ,
        .sat_o            (sat_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] value;
        logic         sat;
    } exp_t;

    exp_t exp_q[$];
    int   samples[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // ADC model: two lead bits forced to 1, then the sample MSB first.
    // A new bit is presented after each sclk rise.
    // ------------------------------------------------------------------
    logic [NB-1:0] frame = '0;
    int            bit_idx = 0;

    always @(negedge adc_csn_o or posedge adc_sclk_o) begin
        if (adc_sclk_o) begin
            bit_idx++;
            adc_miso_i = (bit_idx < NB) ? frame[NB-1-bit_idx] : 1'b0;
        end else begin
            int cur;
            cur = (samples.size() > 0) ? samples.pop_front() : 0;
            frame = {{LEAD{1'b1}}, cur[W-1:0]};
            bit_idx = 0;
            adc_miso_i = frame[NB-1];
        end
    end

    // ------------------------------------------------------------------
    // Monitors, sampled on the falling clock edge.
    // ------------------------------------------------------------------
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    bit           mon_on = 1'b0;
    logic         prev_csn = 1'b1;
    logic         prev_sclk = 1'b0;
    logic         prev_busy = 1'b0;
    logic         prev_strb = 1'b0;
    bit           abort = 1'b0;
    int           low_len = 0;
    int           rises = 0;
    int           busy_len = 0;
    int           fall_cnt = 0;
    int           strobe_cnt = 0;
    int           fall_t[$];
    int           strobe_t[$];
    logic [W-1:0] held = '0;

    always @(negedge clk_i) begin
        if (mon_on) begin
            if (rst_i) abort = 1'b1;

            if (!adc_csn_o) begin
                if (prev_csn) begin
                    low_len = 0;
                    rises = 0;
                    abort = rst_i;
                    fall_cnt++;
                    fall_t.push_back(cyc);
                end
                low_len++;
                if (adc_sclk_o && !prev_sclk) rises++;
            end else begin
                chk("sclk_idle", adc_sclk_o, 1'b0);
                if (!prev_csn && !abort) begin
                    chk("csn_low_len", low_len, CSN_LOW);
                    chk("sclk_rises", rises, NB);
                end
            end

            if (busy_o) busy_len++;
            else begin
                if (prev_busy && !abort) chk("busy_len", busy_len, CONV);
                busy_len = 0;
            end

            if (prev_strb) chk("strb_width", dataValid_STRB_o, 1'b0);
            if (dataValid_STRB_o) begin
                strobe_cnt++;
                strobe_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", ADC_value_o, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("adc_value", ADC_value_o, e.value);
`ifdef ADC_SAT_FLAG_EN
                    chk("sat", sat_o, e.sat);
`endif
                    held = e.value;
                end
            end else begin
                chk("value_hold", ADC_value_o, held);
            end
            if (rst_i) held = '0;

            prev_csn  = adc_csn_o;
            prev_sclk = adc_sclk_o;
            prev_busy = busy_o;
            prev_strb = dataValid_STRB_o;
        end
    end

    // ------------------------------------------------------------------
    // Bounded wait helpers.
    // ------------------------------------------------------------------
    task automatic wait_strobes(input int n, input int budget);
        int tgt;
        int k;
        tgt = strobe_cnt + n;
        k = 0;
        while (strobe_cnt < tgt && k < budget) begin
            @(posedge clk_i);
            k++;
        end
        if (strobe_cnt < tgt) chk("wait_strobe", strobe_cnt, tgt);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_in_shift(input int base, input int nfall, input int nrise);
        int k;
        k = 0;
        while (!(fall_cnt >= base + nfall && rises >= nrise && !adc_csn_o) && k < 400) begin
            @(posedge clk_i);
            k++;
        end
        chk("wait_shift", (k < 400), 1'b1);
        #1;
    endtask

    task automatic push_window(input int a, input int b, input int c, input int d,
                               input logic [W-1:0] avg, input logic sat);
        exp_t e;
        samples.push_back(a);
        samples.push_back(b);
        samples.push_back(c);
        samples.push_back(d);
        e.value = avg;
        e.sat   = sat;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got %0d cycles expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int f0;
        int s0;
        int k;

        repeat (4) @(posedge clk_i);
        #1;
        chk("rst_csn", adc_csn_o, 1'b1);
        chk("rst_sclk", adc_sclk_o, 1'b0);
        chk("rst_value", ADC_value_o, 0);
        chk("rst_strb", dataValid_STRB_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);

        // Whole sample stream in conversion order; the third 50 is cut short
        // by reset and the 99 finishes after en_i drops, so neither is counted.
        push_window(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
        push_window(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
        push_window(0, 0, 0, 3, 8'd0, 1'b0);
        push_window(100, 101, 102, 103, 8'd101, 1'b0);
        samples.push_back(50);
        samples.push_back(50);
        samples.push_back(50);
        push_window(20, 21, 22, 23, 8'd21, 1'b0);
        samples.push_back(30);
        samples.push_back(30);
        samples.push_back(30);
        samples.push_back(99);
        push_window(40, 41, 42, 43, 8'd41, 1'b0);
        push_window(255, 10, 10, 10, 8'd71, 1'b1);
        push_window(10, 10, 10, 10, 8'd10, 1'b0);

        mon_on = 1'b1;
        rst_i  = 1'b0;
        en_i   = 1'b1;

        // Constant 0xA5: latency and strobe spacing.
        wait_strobes(2, 700);
        if (fall_t.size() >= 4 && strobe_t.size() >= 2) begin
            chk("first_strobe_lat", strobe_t[0] - fall_t[0], FIRST_STROBE);
            chk("strobe_after_4th", strobe_t[0] - fall_t[3], CONV);
            chk("strobe_period", strobe_t[1] - strobe_t[0], 4 * SP);
        end else begin
            chk("timing_data", fall_t.size(), 4);
        end

        // Truncating averages.
        wait_strobes(2, 700);

        // Reset during SHIFT of the third conversion of a partial window.
        base = fall_cnt;
        wait_in_shift(base, 3, 3);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mid_csn", adc_csn_o, 1'b1);
        chk("rst_mid_sclk", adc_sclk_o, 1'b0);
        chk("rst_mid_value", ADC_value_o, 0);
        chk("rst_mid_strb", dataValid_STRB_o, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        f0 = fall_cnt;
        s0 = strobe_cnt;
        wait_strobes(1, 700);
        chk("fresh_convs", fall_cnt - f0, 4);
        if (strobe_t.size() > s0 && fall_t.size() > f0)
            chk("rst_first_strobe", strobe_t[s0] - fall_t[f0], FIRST_STROBE);
        else
            chk("rst_timing_data", strobe_t.size(), s0 + 1);

        // Drop en_i during the fourth conversion of a window.
        base = fall_cnt;
        wait_in_shift(base, 4, 2);
        en_i = 1'b0;
        k = 0;
        while (busy_o && k < 200) begin
            @(posedge clk_i);
            k++;
        end
        chk("en_off_idle", busy_o, 1'b0);
        f0 = fall_cnt;
        s0 = strobe_cnt;
        repeat (300) @(posedge clk_i);
        #1;
        chk("en_off_csn", fall_cnt - f0, 0);
        chk("en_off_strobe", strobe_cnt - s0, 0);
        chk("en_off_sclk", adc_sclk_o, 1'b0);
        en_i = 1'b1;
        wait_strobes(1, 700);

        // Saturation window then a clean window.
        wait_strobes(2, 1200);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
